// File: rtl/riscv_rf_pkg.sv
// Shared constants and helpers for the multi-port integer register file.
// Holds default widths, the address-width helper and the hardwired-zero index.
package riscv_rf_pkg;

    localparam int RF_DW   = 32;
    localparam int RF_NREG = 32;

    // Index of the hardwired-zero register.
    localparam int ZERO_ADDR = 0;

    function automatic int rf_addr_w(input int nreg);
        return (nreg <= 1) ? 1 : $clog2(nreg);
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Bus bundle for regfile_mp: read ports, two write ports, issue/flush, busy.
// master = pipeline side driving addresses/writes, slave = register file.
interface regfile_mp_if
    import riscv_rf_pkg::*;
#(
    parameter int DW     = RF_DW,
    parameter int NREG   = RF_NREG,
    parameter int NUM_RD = 2
);

    localparam int AW = rf_addr_w(NREG);

    logic [NUM_RD*AW-1:0] rd_addr;
    logic [NUM_RD*DW-1:0] rd_data;
    logic [NUM_RD-1:0]    rd_busy;
    logic [1:0]           wr_en;
    logic [2*AW-1:0]      wr_addr;
    logic [2*DW-1:0]      wr_data;
    logic                 iss_en;
    logic [AW-1:0]        iss_addr;
    logic                 flush;
    logic                 any_busy;

    modport master (
        output rd_addr, wr_en, wr_addr, wr_data,
        output iss_en, iss_addr, flush,
        input  rd_data, rd_busy, any_busy
    );

    modport slave (
        input  rd_addr, wr_en, wr_addr, wr_data,
        input  iss_en, iss_addr, flush,
        output rd_data, rd_busy, any_busy
    );

endinterface

// File: rtl/rf_read_bypass.sv
// One read port: zero-register mux, write-to-read bypass and busy masking.
// Ports: rd_addr_i, wr_en_i/wr_addr*_i/wr_data*_i, reg_data_i, busy_i -> rd_data_o, rd_busy_o.
module rf_read_bypass
    import riscv_rf_pkg::*;
#(
    parameter int DW       = RF_DW,
    parameter int AW       = 5,
    parameter int ZERO_REG = 1
) (
    input  logic [AW-1:0] rd_addr_i,
    input  logic [1:0]    wr_en_i,
    input  logic [AW-1:0] wr_addr0_i,
    input  logic [AW-1:0] wr_addr1_i,
    input  logic [DW-1:0] wr_data0_i,
    input  logic [DW-1:0] wr_data1_i,
    input  logic [DW-1:0] reg_data_i,
    input  logic          busy_i,
    output logic [DW-1:0] rd_data_o,
    output logic          rd_busy_o
);

    logic is_zero;
    logic hit0;
    logic hit1;

    assign is_zero = (ZERO_REG != 0) && (rd_addr_i == AW'(ZERO_ADDR));
    assign hit0    = wr_en_i[0] && (wr_addr0_i == rd_addr_i);
    assign hit1    = wr_en_i[1] && (wr_addr1_i == rd_addr_i);

    // Port 1 is checked first so the bypassed value matches what gets stored.
    always_comb begin
        rd_data_o = reg_data_i;
        if (is_zero) begin
            rd_data_o = '0;
        end else if (hit1) begin
            rd_data_o = wr_data1_i;
        end else if (hit0) begin
            rd_data_o = wr_data0_i;
        end
    end

    // A same-cycle writeback already delivers the value, so the reader need not stall.
    assign rd_busy_o = busy_i && !(hit0 || hit1) && !is_zero;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port integer register file with write bypass and per-register busy scoreboard.
// Ports: clk, rst (async, active-high), bus (regfile_mp_if.slave: reads, writes, issue, flush, busy).
module regfile_mp
    import riscv_rf_pkg::*;
#(
    parameter int DW       = RF_DW,
    parameter int NREG     = RF_NREG,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input logic         clk,
    input logic         rst,
    regfile_mp_if.slave bus
);

    localparam int AW = rf_addr_w(NREG);

    logic [DW-1:0]   regs_q [NREG];
    logic [DW-1:0]   regs_d [NREG];
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            any_busy_q;

    logic [AW-1:0] wa0;
    logic [AW-1:0] wa1;
    logic [DW-1:0] wd0;
    logic [DW-1:0] wd1;

    assign wa0 = bus.wr_addr[0 +: AW];
    assign wa1 = bus.wr_addr[AW +: AW];
    assign wd0 = bus.wr_data[0 +: DW];
    assign wd1 = bus.wr_data[DW +: DW];

    // Port 1 is applied last so it wins a same-address collision.
    always_comb begin
        regs_d = regs_q;
        if (bus.wr_en[0]) begin
            regs_d[wa0] = wd0;
        end
        if (bus.wr_en[1]) begin
            regs_d[wa1] = wd1;
        end
        if (ZERO_REG != 0) begin
            regs_d[ZERO_ADDR] = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    // Issue beats writeback: the newer producer owns the register.
    always_comb begin
        busy_d = busy_q;
        for (int r = 0; r < NREG; r++) begin
            if (bus.flush) begin
                busy_d[r] = 1'b0;
            end else if (bus.iss_en && (bus.iss_addr == AW'(r))) begin
                busy_d[r] = 1'b1;
            end else if ((bus.wr_en[0] && (wa0 == AW'(r))) ||
                         (bus.wr_en[1] && (wa1 == AW'(r)))) begin
                busy_d[r] = 1'b0;
            end
        end
        if (ZERO_REG != 0) begin
            busy_d[ZERO_ADDR] = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q     <= '0;
            any_busy_q <= 1'b0;
        end else begin
            busy_q     <= busy_d;
            any_busy_q <= |busy_d;
        end
    end

    assign bus.any_busy = any_busy_q;

    wire [NUM_RD*DW-1:0] rd_data_w;
    wire [NUM_RD-1:0]    rd_busy_w;

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [AW-1:0] ra;
        assign ra = bus.rd_addr[k*AW +: AW];

        rf_read_bypass #(
            .DW       (DW),
            .AW       (AW),
            .ZERO_REG (ZERO_REG)
        ) u_rd (
            .rd_addr_i  (ra),
            .wr_en_i    (bus.wr_en),
            .wr_addr0_i (wa0),
            .wr_addr1_i (wa1),
            .wr_data0_i (wd0),
            .wr_data1_i (wd1),
            .reg_data_i (regs_q[ra]),
            .busy_i     (busy_q[ra]),
            .rd_data_o  (rd_data_w[k*DW +: DW]),
            .rd_busy_o  (rd_busy_w[k])
        );
    end

    assign bus.rd_data = rd_data_w;
    assign bus.rd_busy = rd_busy_w;

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed table, corner sequences, random vs model.
// Model keeps register values and busy flags as plain arrays updated per clock.
module tb_regfile_mp;

    logic clk;
    logic rst;

    regfile_mp_if #(.DW(32), .NREG(32), .NUM_RD(2)) bus ();

    regfile_mp #(
        .DW       (32),
        .NREG     (32),
        .NUM_RD   (2),
        .ZERO_REG (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk;
    int n_fail;

    logic [31:0] m_reg  [32];
    logic        m_busy [32];

    typedef struct {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic        iss;
        logic [4:0]  ia;
        logic        fl;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] e_rd0;
        logic [31:0] e_rd1;
        logic        e_b0;
        logic        e_b1;
        logic        e_any;
    } vec_t;

    vec_t tbl [11];

    function automatic vec_t mkv(
        input int unsigned we, input int unsigned wa0, input logic [31:0] wd0,
        input int unsigned wa1, input logic [31:0] wd1,
        input int unsigned iss, input int unsigned ia, input int unsigned fl,
        input int unsigned ra0, input int unsigned ra1,
        input logic [31:0] e0, input logic [31:0] e1,
        input int unsigned b0, input int unsigned b1, input int unsigned an);
        vec_t v;
        v.we = 2'(we); v.wa0 = 5'(wa0); v.wd0 = wd0;
        v.wa1 = 5'(wa1); v.wd1 = wd1;
        v.iss = 1'(iss); v.ia = 5'(ia); v.fl = 1'(fl);
        v.ra0 = 5'(ra0); v.ra1 = 5'(ra1);
        v.e_rd0 = e0; v.e_rd1 = e1;
        v.e_b0 = 1'(b0); v.e_b1 = 1'(b1); v.e_any = 1'(an);
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] we, input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic iss, input logic [4:0] ia, input logic fl,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        bus.wr_en    = we;
        bus.wr_addr  = {wa1, wa0};
        bus.wr_data  = {wd1, wd0};
        bus.iss_en   = iss;
        bus.iss_addr = ia;
        bus.flush    = fl;
        bus.rd_addr  = {ra1, ra0};
    endtask

    task automatic idle(input logic [4:0] ra0, input logic [4:0] ra1);
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, ra0, ra1);
    endtask

    // Reference behaviour of one clock edge, from the architectural rules.
    function automatic void model_upd();
        logic [4:0] wa [2];
        wa[0] = bus.wr_addr[4:0];
        wa[1] = bus.wr_addr[9:5];
        if (rst) begin
            for (int i = 0; i < 32; i++) begin
                m_reg[i] = 0;
                m_busy[i] = 0;
            end
            return;
        end
        for (int j = 0; j < 2; j++)
            if (bus.wr_en[j] && wa[j] != 0)
                m_reg[wa[j]] = bus.wr_data[j*32 +: 32];
        if (bus.flush) begin
            for (int i = 0; i < 32; i++) m_busy[i] = 0;
        end else begin
            for (int j = 0; j < 2; j++)
                if (bus.wr_en[j]) m_busy[wa[j]] = 0;
            if (bus.iss_en) m_busy[bus.iss_addr] = 1;
            m_busy[0] = 0;
        end
    endfunction

    function automatic logic [31:0] m_rd(input logic [4:0] a);
        if (a == 0) return 0;
        if (bus.wr_en[1] && bus.wr_addr[9:5] == a) return bus.wr_data[63:32];
        if (bus.wr_en[0] && bus.wr_addr[4:0] == a) return bus.wr_data[31:0];
        return m_reg[a];
    endfunction

    function automatic logic m_rbusy(input logic [4:0] a);
        logic wr_hit;
        wr_hit = (bus.wr_en[1] && bus.wr_addr[9:5] == a) ||
                 (bus.wr_en[0] && bus.wr_addr[4:0] == a);
        return (a != 0) && m_busy[a] && !wr_hit;
    endfunction

    function automatic logic m_any();
        logic o;
        o = 0;
        for (int i = 0; i < 32; i++) o = o | m_busy[i];
        return o;
    endfunction

    // Finish the current cycle: clock edge, model step, return at the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_upd();
        @(negedge clk);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        for (int i = 0; i < 32; i++) begin
            m_reg[i] = 0;
            m_busy[i] = 0;
        end

        tbl[0]  = mkv(1, 7, 32'h12345678, 0, 0, 0, 0, 0, 7, 0, 32'h12345678, 0, 0, 0, 0);
        tbl[1]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 32'h12345678, 0, 0, 0, 0);
        tbl[2]  = mkv(3, 3, 32'h1, 3, 32'h2, 0, 0, 0, 3, 7, 32'h2, 32'h12345678, 0, 0, 0);
        tbl[3]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 3, 0, 32'h2, 0, 0, 0, 0);
        tbl[4]  = mkv(1, 0, 32'hFFFFFFFF, 0, 0, 1, 0, 0, 0, 3, 0, 32'h2, 0, 0, 0);
        tbl[5]  = mkv(0, 0, 0, 0, 0, 1, 10, 0, 10, 0, 0, 0, 0, 0, 0);
        tbl[6]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 10, 0, 0, 0, 1, 0, 1);
        tbl[7]  = mkv(2, 0, 0, 10, 32'hAAAA5555, 1, 10, 0, 10, 0, 32'hAAAA5555, 0, 0, 0, 1);
        tbl[8]  = mkv(0, 0, 0, 0, 0, 0, 0, 0, 10, 0, 32'hAAAA5555, 0, 1, 0, 1);
        tbl[9]  = mkv(1, 10, 32'h0BADF00D, 0, 0, 0, 0, 0, 10, 0, 32'h0BADF00D, 0, 0, 0, 1);
        tbl[10] = mkv(0, 0, 0, 0, 0, 0, 0, 0, 10, 0, 32'h0BADF00D, 0, 0, 0, 0);

        rst = 1'b1;
        idle(5'd5, 5'd0);
        #3;
        chk("reset_rd0", bus.rd_data[31:0], 32'd0);
        chk("reset_any", 32'(bus.any_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].we, tbl[i].wa0, tbl[i].wd0, tbl[i].wa1, tbl[i].wd1,
                  tbl[i].iss, tbl[i].ia, tbl[i].fl, tbl[i].ra0, tbl[i].ra1);
            #2;
            chk($sformatf("tbl%0d_rd0", i), bus.rd_data[31:0], tbl[i].e_rd0);
            chk($sformatf("tbl%0d_rd1", i), bus.rd_data[63:32], tbl[i].e_rd1);
            chk($sformatf("tbl%0d_busy0", i), 32'(bus.rd_busy[0]), 32'(tbl[i].e_b0));
            chk($sformatf("tbl%0d_busy1", i), 32'(bus.rd_busy[1]), 32'(tbl[i].e_b1));
            chk($sformatf("tbl%0d_any", i), 32'(bus.any_busy), 32'(tbl[i].e_any));
            cyc();
        end

        // Flush beats a same-cycle issue.
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd1, 1'b0, 5'd0, 5'd0);
        cyc();
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd2, 1'b0, 5'd0, 5'd0);
        cyc();
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd31, 1'b0, 5'd0, 5'd0);
        cyc();
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd4, 1'b1, 5'd1, 5'd31);
        #2;
        chk("fl_pre_b1", 32'(bus.rd_busy[0]), 32'd1);
        chk("fl_pre_b31", 32'(bus.rd_busy[1]), 32'd1);
        chk("fl_pre_any", 32'(bus.any_busy), 32'd1);
        cyc();
        idle(5'd4, 5'd2);
        #2;
        chk("fl_b4", 32'(bus.rd_busy[0]), 32'd0);
        chk("fl_b2", 32'(bus.rd_busy[1]), 32'd0);
        cyc();
        idle(5'd1, 5'd31);
        #2;
        chk("fl_b1", 32'(bus.rd_busy[0]), 32'd0);
        chk("fl_b31", 32'(bus.rd_busy[1]), 32'd0);
        chk("fl_any", 32'(bus.any_busy), 32'd0);
        cyc();

        // Asynchronous reset in the middle of activity.
        drive(2'b00, 5'd0, 32'd0, 5'd0, 32'd0, 1'b1, 5'd9, 1'b0, 5'd0, 5'd0);
        cyc();
        drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 5'd0);
        cyc();
        drive(2'b01, 5'd6, 32'h00001111, 5'd0, 32'd0, 1'b1, 5'd12, 1'b0, 5'd5, 5'd9);
        #2;
        chk("rs_pre_x5", bus.rd_data[31:0], 32'hDEADBEEF);
        chk("rs_pre_b9", 32'(bus.rd_busy[1]), 32'd1);
        chk("rs_pre_any", 32'(bus.any_busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rs_x5", bus.rd_data[31:0], 32'd0);
        chk("rs_b9", 32'(bus.rd_busy[1]), 32'd0);
        chk("rs_any", 32'(bus.any_busy), 32'd0);
        cyc();
        rst = 1'b0;
        idle(5'd12, 5'd0);
        #2;
        chk("rs_b12", 32'(bus.rd_busy[0]), 32'd0);
        chk("rs_any_after", 32'(bus.any_busy), 32'd0);
        for (int i = 0; i < 32; i++) begin
            bus.rd_addr = {5'(31 - i), 5'(i)};
            #1;
            chk($sformatf("rs_zero_x%0d", i), bus.rd_data[31:0], 32'd0);
        end
        cyc();

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] a [5];
            for (int k = 0; k < 5; k++)
                a[k] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 5)) : 5'($urandom);
            drive(2'($urandom), a[0], $urandom, a[1], $urandom,
                  1'($urandom_range(0, 2) == 0), a[2],
                  1'($urandom_range(0, 19) == 0), a[3], a[4]);
            #2;
            chk("rnd_rd0", bus.rd_data[31:0], m_rd(a[3]));
            chk("rnd_rd1", bus.rd_data[63:32], m_rd(a[4]));
            chk("rnd_busy0", 32'(bus.rd_busy[0]), 32'(m_rbusy(a[3])));
            chk("rnd_busy1", 32'(bus.rd_busy[1]), 32'(m_rbusy(a[4])));
            chk("rnd_any", 32'(bus.any_busy), 32'(m_any()));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port integer register file for the next RV32 pipeline generation.
- Provides NUM_RD combinational read ports and two synchronous write ports: port 0 for the ALU/WB path, port 1 for the load/late path.
- Write-to-read bypass lets readers see same-cycle writes.
- Per-register busy scoreboard, set at issue and cleared at writeback, lets decode stall on RAW hazards without an external scoreboard.

Parameters:
- DW, 32, register data width in bits.
- NREG, 32, number of architectural registers (power of 2).
- AW, $clog2(NREG), address width, derived; do not override.
- NUM_RD, 2, number of read ports (1..4).
- ZERO_REG, 1, when 1, register 0 reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- rd_addr  in  NUM_RD*AW  packed read addresses; port k occupies bits [k*AW +: AW].
- rd_data  out  NUM_RD*DW  packed read data, combinational.
- rd_busy  out  NUM_RD  busy flag of each addressed register, after bypass.
- wr_en  in  2  write enable per write port.
- wr_addr  in  2*AW  write addresses; port j occupies [j*AW +: AW].
- wr_data  in  2*DW  write data; port j occupies [j*DW +: DW].
- iss_en  in  1  instruction issued with a destination register.
- iss_addr  in  AW  destination register being marked busy.
- flush  in  1  clear all busy bits (pipeline flush).
- any_busy  out  1  OR of all busy bits, registered.

Behaviour:
- Reset (async): all NREG registers = 0, all busy bits = 0, any_busy = 0. rd_data reflects zeroed state immediately.
- Write: on posedge, if wr_en[j] and the address is writable, reg[wr_addr_j] <= wr_data_j.
  - Address 0 is not writable when ZERO_REG=1.
  - Both ports writing the same address in one cycle: port 1 wins.
- Read, combinational:
  - rd_data_k = 0 if ZERO_REG and rd_addr_k == 0.
  - Else wr_data_1 if wr_en[1] and the address matches port 1.
  - Else wr_data_0 if wr_en[0] and the address matches port 0.
  - Else reg[rd_addr_k].
  - Write-to-read latency is therefore 0 cycles (bypass). This replaces any negedge write scheme; no negedge logic is permitted.
- Busy scoreboard, per register r, next state by priority:
  - flush -> 0.
  - Else if iss_en and iss_addr == r -> 1. Issue beats same-cycle writeback, because the newer producer owns r.
  - Else if any wr_en[j] with wr_addr_j == r -> 0.
  - Else hold.
  - busy[0] is held at 0 when ZERO_REG=1.
- flush with iss_en in the same cycle: flush wins; all busy bits = 0 after the edge.
- rd_busy_k = busy[rd_addr_k] AND NOT (any write port targeting rd_addr_k this cycle), which reflects the bypass. It is forced to 0 for register 0 when ZERO_REG=1.
- any_busy: registered OR of next-state busy bits, so it is valid one cycle after the update.
- Writes to non-busy registers are legal; they write data and leave busy at 0.
- Reset asserted mid-operation: immediate clear of all state. Writes and issues in the reset cycle are discarded.
- Out-of-range addresses cannot occur, since NREG is a power of 2.

Decomposition:
- Shared package riscv_rf_pkg holds:
  - the localparam defaults (DW, NREG);
  - a function rf_addr_w(NREG);
  - a constant ZERO_ADDR = 0.
- One sub-module, rf_read_bypass: a single read port's bypass/zero mux plus rd_busy logic, instantiated NUM_RD times in a generate loop.
- Storage and the scoreboard stay in the top module.

Test Plan:
- Reset: assert rst mid-run after writing x5=0xDEADBEEF -> rd_data for x5 = 0 immediately, any_busy = 0 next cycle; deassert, read all regs -> 0.
- Write/bypass: wr_en[0]=1, addr 7, data 0x12345678, rd_addr0=7 in the same cycle -> rd_data0 = 0x12345678 combinationally; next cycle with wr_en=0 -> still 0x12345678.
- Port conflict: both ports write x3, port 0 data 0x1, port 1 data 0x2 -> bypassed read = 0x2; stored value after the edge = 0x2.
- Zero register: write x0=0xFFFFFFFF, iss_en addr 0 -> rd_data = 0, rd_busy = 0, any_busy stays 0.
- Scoreboard: iss_en x10 -> rd_busy for x10 = 1 next cycle. In a later cycle, wr_en[1] x10 together with iss_en x10 -> busy stays 1, while rd_busy that same cycle = 0. Next cycle, wr_en[0] x10 alone -> busy = 0.
- Flush: mark x1, x2, x31 busy, then flush together with iss_en x4 -> all busy = 0 next cycle, any_busy = 0 the cycle after.
